// File: rtl/sreg_pkg.sv
// Shared types and constants for the configuration-link frame receiver.
// Build option: SREG_READBACK_EN enables shadow preload and MISO readback.
package sreg_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_DYN  = 2'd1,
    SHIFT_STAT = 2'd2
  } state_e;

  localparam int SIZESRDYN_DEF   = 16;
  localparam int SIZESRSTAT_DEF  = 88;
  localparam int GAP_TIMEOUT_DEF = 8;

  // Values the committed words and single-bit outputs take in reset
  localparam logic [SIZESRDYN_DEF-1:0]  DYN_RST_WORD  = '0;
  localparam logic [SIZESRSTAT_DEF-1:0] STAT_RST_WORD = '0;
  localparam logic                      RST_BIT       = 1'b0;

endpackage

// File: rtl/sreg_shifter.sv
// Shadow shift register plus committed parallel word for one register bank.
// Build option: SREG_READBACK_EN reloads the shadow from the committed word
// while the bank is not being shifted, so the MSB tap reads back old contents.
module sreg_shifter
  import sreg_pkg::*;
#(
  parameter int               WIDTH    = SIZESRDYN_DEF,
  parameter logic [WIDTH-1:0] RST_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_i,
  input  logic             shift_i,
  input  logic             commit_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] reg_o,
  output logic             msb_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] shifted;

  // Next shadow/committed values; a shift always wins over a preload
  always_comb begin
    shifted  = {shadow_q[WIDTH-2:0], bit_i};
    shadow_d = shadow_q;
    reg_d    = reg_q;
    if (shift_i) begin
      shadow_d = shifted;
    end
`ifdef SREG_READBACK_EN
    else if (load_i) begin
      shadow_d = reg_q;
    end
`endif
    if (commit_i) begin
      reg_d = shifted;
    end
  end

`ifdef SREG_READBACK_EN
`else
  logic unused_load;
  assign unused_load = load_i;
`endif

  // Shadow and committed word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_WORD;
      reg_q    <= RST_WORD;
    end else begin
      shadow_q <= shadow_d;
      reg_q    <= reg_d;
    end
  end

  assign reg_o = reg_q;
  assign msb_o = shadow_q[WIDTH-1];

endmodule

// File: rtl/sreg_frame_rx.sv
// Receive-side deserializer: assembles SEL/MOSI bit frames into the dynamic
// and static registers, pulsing an update strobe per frame and FRAME_ERR on
// interrupted or timed-out frames.
// Build option: SREG_READBACK_EN drives MISO with the previous register
// contents, MSB first; otherwise MISO stays 0.
module sreg_frame_rx
  import sreg_pkg::*;
#(
  parameter int SIZESRDYN   = SIZESRDYN_DEF,
  parameter int SIZESRSTAT  = SIZESRSTAT_DEF,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SEL,
  input  logic                  MOSI,
  input  logic                  BIT_VALID,
  output logic [SIZESRDYN-1:0]  DYN_REG,
  output logic [SIZESRSTAT-1:0] STAT_REG,
  output logic                  DYN_UPD,
  output logic                  STAT_UPD,
  output logic                  FRAME_ERR,
  output logic                  BUSY,
  output logic                  MISO
);

  localparam int CNT_W = $clog2(SIZESRSTAT + 1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DYN_LAST  = CNT_W'(SIZESRDYN);
  localparam logic [CNT_W-1:0] STAT_LAST = CNT_W'(SIZESRSTAT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
  logic             dyn_upd_q, dyn_upd_d;
  logic             stat_upd_q, stat_upd_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             miso_q, miso_d;

  logic dyn_last, stat_last, gap_hit;
  logic mismatch, timeout, new_frame;
  logic dyn_shift, stat_shift, dyn_commit, stat_commit;
  logic dyn_load, stat_load;
  logic dyn_msb, stat_msb;

  // Frame events decoded from the current state and the incoming bit
  always_comb begin
    cnt_inc   = bit_cnt_q + CNT_W'(1);
    gap_inc   = gap_cnt_q + GAP_W'(1);
    dyn_last  = (cnt_inc == DYN_LAST);
    stat_last = (cnt_inc == STAT_LAST);
    gap_hit   = (gap_inc == GAP_LAST);
    mismatch  = BIT_VALID && (((state_q == SHIFT_DYN) && !SEL) ||
                              ((state_q == SHIFT_STAT) && SEL));
    // An accepted bit always beats an expiring gap counter
    timeout   = !BIT_VALID && (state_q != IDLE) && gap_hit;
    new_frame = BIT_VALID && ((state_q == IDLE) || mismatch);
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (new_frame) begin
      state_d = SEL ? SHIFT_DYN : SHIFT_STAT;
    end else if (BIT_VALID) begin
      if ((state_q == SHIFT_DYN && dyn_last) || (state_q == SHIFT_STAT && stat_last)) begin
        state_d = IDLE;
      end
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: shift/commit/preload controls and registered pulse values
  always_comb begin
    dyn_shift   = BIT_VALID && SEL;
    stat_shift  = BIT_VALID && !SEL;
    dyn_commit  = dyn_shift && (state_q == SHIFT_DYN) && dyn_last;
    stat_commit = stat_shift && (state_q == SHIFT_STAT) && stat_last;
    dyn_load    = (state_q != SHIFT_DYN);
    stat_load   = (state_q != SHIFT_STAT);
    dyn_upd_d   = dyn_commit;
    stat_upd_d  = stat_commit;
    frame_err_d = mismatch || timeout;
    busy_d      = (state_d != IDLE);
  end

  // Bit and gap counter next values
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (new_frame) begin
      bit_cnt_d = CNT_W'(1);
    end else if (dyn_commit || stat_commit || timeout) begin
      bit_cnt_d = '0;
    end else if (BIT_VALID) begin
      bit_cnt_d = cnt_inc;
    end
    if (BIT_VALID || (state_q == IDLE) || timeout) begin
      gap_cnt_d = '0;
    end else begin
      gap_cnt_d = gap_inc;
    end
  end

  // Readback bit: MSB of the selected shadow before it shifts
  always_comb begin
`ifdef SREG_READBACK_EN
    miso_d = miso_q;
    if (BIT_VALID) begin
      miso_d = SEL ? dyn_msb : stat_msb;
    end
`else
    miso_d = RST_BIT;
`endif
  end

`ifdef SREG_READBACK_EN
`else
  logic unused_msb;
  assign unused_msb = dyn_msb ^ stat_msb;
`endif

  // Counters and registered single-bit outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      dyn_upd_q   <= RST_BIT;
      stat_upd_q  <= RST_BIT;
      frame_err_q <= RST_BIT;
      busy_q      <= RST_BIT;
      miso_q      <= RST_BIT;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dyn_upd_q   <= dyn_upd_d;
      stat_upd_q  <= stat_upd_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
    end
  end

  sreg_shifter #(
    .WIDTH    (SIZESRDYN),
    .RST_WORD (SIZESRDYN'(DYN_RST_WORD))
  ) u_dyn (
    .clk      (CLK),
    .rst_n    (RST_N),
    .bit_i    (MOSI),
    .shift_i  (dyn_shift),
    .commit_i (dyn_commit),
    .load_i   (dyn_load),
    .reg_o    (DYN_REG),
    .msb_o    (dyn_msb)
  );

  sreg_shifter #(
    .WIDTH    (SIZESRSTAT),
    .RST_WORD (SIZESRSTAT'(STAT_RST_WORD))
  ) u_stat (
    .clk      (CLK),
    .rst_n    (RST_N),
    .bit_i    (MOSI),
    .shift_i  (stat_shift),
    .commit_i (stat_commit),
    .load_i   (stat_load),
    .reg_o    (STAT_REG),
    .msb_o    (stat_msb)
  );

  assign DYN_UPD   = dyn_upd_q;
  assign STAT_UPD  = stat_upd_q;
  assign FRAME_ERR = frame_err_q;
  assign BUSY      = busy_q;
  assign MISO      = miso_q;

endmodule

// File: tb/tb_sreg_frame_rx.sv
// Self-checking bench for sreg_frame_rx with a queue-based scoreboard.
module tb_sreg_frame_rx;

  localparam int DW = 16;
  localparam int SW = 88;

  logic          CLK = 1'b0;
  logic          RST_N, SEL, MOSI, BIT_VALID;
  logic [DW-1:0] DYN_REG;
  logic [SW-1:0] STAT_REG;
  logic          DYN_UPD, STAT_UPD, FRAME_ERR, BUSY, MISO;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [DW-1:0] dyn_q[$];
  logic [SW-1:0] stat_q[$];
  logic          err_q[$];

  localparam logic [SW-1:0] W_S1 = 88'h123456789ABCDEF1234567;
  localparam logic [SW-1:0] W_S2 = 88'hFEDCBA9876543210ABCDEF;
  localparam logic [SW-1:0] W_S3 = 88'hA5A55A5A0123456789ABCD;
  localparam logic [SW-1:0] W_S4 = 88'h00FF00FF_C3C3_3C3C_5555AA;

  always #5 CLK = ~CLK;

  sreg_frame_rx dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SEL       (SEL),
    .MOSI      (MOSI),
    .BIT_VALID (BIT_VALID),
    .DYN_REG   (DYN_REG),
    .STAT_REG  (STAT_REG),
    .DYN_UPD   (DYN_UPD),
    .STAT_UPD  (STAT_UPD),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY),
    .MISO      (MISO)
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    BIT_VALID = 1'b0;
    SEL       = 1'b0;
    MOSI      = 1'b0;
  endtask

  task automatic send_bit(input logic sel, input logic b);
    @(negedge CLK);
    BIT_VALID = 1'b1;
    SEL       = sel;
    MOSI      = b;
  endtask

  // Bits w[hi] down to w[lo], with 'gap' idle cycles between consecutive bits
  task automatic send_bits(input logic sel, input logic [127:0] w, input int hi, input int lo, input int gap);
    for (int i = hi; i >= lo; i--) begin
      if (i != hi) repeat (gap) idle_cycle();
      send_bit(sel, w[i]);
    end
  endtask

  // Observe the result of the edge that samples the last driven inputs
  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation
  always @(negedge CLK) begin
    if (mon_en && RST_N) begin
      if (DYN_UPD) begin
        if (dyn_q.size() == 0) check_eq("dyn_upd_unexpected", DYN_UPD, 1'b0);
        else check_eq("sb_dyn_reg", DYN_REG, dyn_q.pop_front());
      end
      if (STAT_UPD) begin
        if (stat_q.size() == 0) check_eq("stat_upd_unexpected", STAT_UPD, 1'b0);
        else check_eq("sb_stat_reg", STAT_REG, stat_q.pop_front());
      end
      if (FRAME_ERR) begin
        if (err_q.size() == 0) check_eq("frame_err_unexpected", FRAME_ERR, 1'b0);
        else check_eq("sb_frame_err", FRAME_ERR, err_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] last_dyn;
    logic          exp_miso;

    RST_N = 1'b0; BIT_VALID = 1'b0; SEL = 1'b0; MOSI = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_dyn_reg",   DYN_REG,   '0);
    check_eq("rst_stat_reg",  STAT_REG,  '0);
    check_eq("rst_dyn_upd",   DYN_UPD,   1'b0);
    check_eq("rst_stat_upd",  STAT_UPD,  1'b0);
    check_eq("rst_frame_err", FRAME_ERR, 1'b0);
    check_eq("rst_busy",      BUSY,      1'b0);
    check_eq("rst_miso",      MISO,      1'b0);
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back dynamic then static frame
    last_dyn = 16'hABCD;
    dyn_q.push_back(last_dyn);
    stat_q.push_back(W_S1);
    send_bits(1'b1, 128'(last_dyn), DW-1, 0, 0);
    settle();
    check_eq("b2b_dyn_upd", DYN_UPD, 1'b1);
    check_eq("b2b_dyn_reg", DYN_REG, last_dyn);
    send_bits(1'b0, 128'(W_S1), SW-1, 0, 0);
    settle();
    check_eq("b2b_stat_upd",  STAT_UPD, 1'b1);
    check_eq("b2b_stat_reg",  STAT_REG, W_S1);
    check_eq("b2b_busy_fall", BUSY,     1'b0);
    idle_cycle();
    idle_cycle();

    // SEL mismatch after 10 dynamic bits restarts as a static frame
    send_bits(1'b1, 128'(16'h5A5A), DW-1, DW-10, 0);
    err_q.push_back(1'b1);
    stat_q.push_back(W_S2);
    send_bit(1'b0, W_S2[SW-1]);
    settle();
    check_eq("mm_frame_err", FRAME_ERR, 1'b1);
    check_eq("mm_busy",      BUSY,      1'b1);
    check_eq("mm_dyn_keep",  DYN_REG,   last_dyn);
    send_bits(1'b0, 128'(W_S2), SW-2, 0, 0);
    settle();
    check_eq("mm_stat_upd", STAT_UPD, 1'b1);
    check_eq("mm_stat_reg", STAT_REG, W_S2);
    idle_cycle();

    // Gap timeout after 5 static bits
    send_bits(1'b0, 128'(W_S3), SW-1, SW-5, 0);
    repeat (7) idle_cycle();
    settle();
    check_eq("gap7_no_err", FRAME_ERR, 1'b0);
    check_eq("gap7_busy",   BUSY,      1'b1);
    err_q.push_back(1'b1);
    idle_cycle();
    settle();
    check_eq("gap8_frame_err", FRAME_ERR, 1'b1);
    check_eq("gap8_busy",      BUSY,      1'b0);
    check_eq("gap8_stat_keep", STAT_REG,  W_S2);
    idle_cycle();

    // Bit arriving on the 8th gap cycle keeps the frame alive
    stat_q.push_back(W_S3);
    send_bits(1'b0, 128'(W_S3), SW-1, SW-5, 0);
    repeat (7) idle_cycle();
    send_bit(1'b0, W_S3[SW-6]);
    settle();
    check_eq("gapbv_no_err", FRAME_ERR, 1'b0);
    check_eq("gapbv_busy",   BUSY,      1'b1);
    send_bits(1'b0, 128'(W_S3), SW-7, 0, 0);
    settle();
    check_eq("gapbv_stat_reg", STAT_REG, W_S3);
    idle_cycle();

    // Reset in the middle of a static frame
    send_bits(1'b0, 128'(W_S1), SW-1, SW-40, 0);
    @(negedge CLK);
    BIT_VALID = 1'b0;
    RST_N     = 1'b0;
    #1;
    check_eq("mrst_dyn_reg",  DYN_REG,   '0);
    check_eq("mrst_stat_reg", STAT_REG,  '0);
    check_eq("mrst_busy",     BUSY,      1'b0);
    check_eq("mrst_err",      FRAME_ERR, 1'b0);
    check_eq("mrst_miso",     MISO,      1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    stat_q.push_back(W_S4);
    send_bits(1'b0, 128'(W_S4), SW-1, 0, 0);
    settle();
    check_eq("mrst_fresh_upd",  STAT_UPD, 1'b1);
    check_eq("mrst_fresh_stat", STAT_REG, W_S4);
    check_eq("mrst_fresh_dyn",  DYN_REG,  '0);
    idle_cycle();

    // Gapped bits (every 3rd cycle) commit the same as contiguous frames
    dyn_q.push_back(last_dyn);
    stat_q.push_back(W_S1);
    send_bits(1'b1, 128'(last_dyn), DW-1, 0, 2);
    settle();
    check_eq("gapd_dyn_upd", DYN_UPD, 1'b1);
    check_eq("gapd_dyn_reg", DYN_REG, last_dyn);
    check_eq("gapd_busy",    BUSY,    1'b0);
    repeat (2) idle_cycle();
    send_bits(1'b0, 128'(W_S1), SW-1, 0, 2);
    settle();
    check_eq("gapd_stat_reg", STAT_REG, W_S1);
    idle_cycle();
    idle_cycle();

    // Readback: zeros shifted in, previous dynamic word comes out on MISO
    dyn_q.push_back(16'h0000);
    for (int i = DW-1; i >= 0; i--) begin
      send_bit(1'b1, 1'b0);
      settle();
`ifdef SREG_READBACK_EN
      exp_miso = last_dyn[i];
`else
      exp_miso = 1'b0;
`endif
      check_eq($sformatf("rb_miso_%0d", i), MISO, exp_miso);
    end
    check_eq("rb_dyn_upd", DYN_UPD, 1'b1);
    check_eq("rb_dyn_reg", DYN_REG, 16'h0000);
    last_dyn = 16'h0000;
    repeat (4) idle_cycle();

    check_eq("sb_dyn_empty",  dyn_q.size(),  0);
    check_eq("sb_stat_empty", stat_q.size(), 0);
    check_eq("sb_err_empty",  err_q.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
